pwm_fader: RTL and testbench

PWM_FADER -- requirements
Module: pwm_fader

---
 rtl/pwm_fader.sv | 114 +++++++++++
 tb/tb_pwm_fader.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/pwm_fader.sv
// rtl/pwm_fader.sv - Duty-cycle ramp generator that steps a PWM value toward a target once per N periods.
// Steps are taken only on sync rising edges, so value_out stays constant across whole PWM periods.
module pwm_fader #(
  parameter int WIDTH = 8,
  parameter int INIT  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sync,
  input  logic [WIDTH-1:0] target,
  input  logic [WIDTH-1:0] step,
  input  logic [7:0]       interval,
  input  logic             target_valid,
  output logic             target_ready,
  input  logic             abort,
  output logic [WIDTH-1:0] value_out,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] LP_INIT = WIDTH'(INIT);
  localparam logic [WIDTH-1:0] LP_ONE  = WIDTH'(1);

  typedef enum logic [1:0] {S_IDLE, S_UP, S_DOWN} state_t;

  state_t           r_state;
  logic             r_sync_d;
  logic [7:0]       r_cnt;
  logic [7:0]       r_interval;
  logic [WIDTH-1:0] r_target;
  logic [WIDTH-1:0] r_step;
  logic [WIDTH-1:0] r_value;
  logic             r_done;

  logic             w_tick;
  logic [7:0]       w_cnt_inc;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic             w_up_hit;
  logic             w_dn_hit;

  assign w_tick    = sync & ~r_sync_d;
  assign w_cnt_inc = r_cnt + 8'd1;
  // One extra bit makes overshoot past the top and underflow past zero both visible.
  assign w_sum     = {1'b0, r_value} + {1'b0, r_step};
  assign w_diff    = {1'b0, r_value} - {1'b0, r_step};
  assign w_up_hit  = (w_sum >= {1'b0, r_target});
  assign w_dn_hit  = w_diff[WIDTH] || (w_diff[WIDTH-1:0] <= r_target);

  assign target_ready = (r_state == S_IDLE);
  assign busy         = (r_state == S_UP) || (r_state == S_DOWN);
  assign value_out    = r_value;
  assign done         = r_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_sync_d   <= 1'b1;
      r_cnt      <= 8'd0;
      r_interval <= 8'd1;
      r_target   <= LP_INIT;
      r_step     <= LP_ONE;
      r_value    <= LP_INIT;
      r_done     <= 1'b0;
    end else begin
      r_sync_d <= sync;
      r_done   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (target_valid) begin
            r_target   <= target;
            r_step     <= (step == '0) ? LP_ONE : step;
            r_interval <= (interval == 8'd0) ? 8'd1 : interval;
            r_cnt      <= 8'd0;
            if (target > r_value)      r_state <= S_UP;
            else if (target < r_value) r_state <= S_DOWN;
            else                       r_done  <= 1'b1;
          end
        end
        S_UP, S_DOWN: begin
          // Abort takes priority over a coincident step, leaving value_out untouched.
          if (abort) begin
            r_state <= S_IDLE;
          end else if (w_tick) begin
            if (w_cnt_inc == r_interval) begin
              r_cnt <= 8'd0;
              if (r_state == S_UP) begin
                if (w_up_hit) begin
                  r_value <= r_target;
                  r_state <= S_IDLE;
                  r_done  <= 1'b1;
                end else begin
                  r_value <= w_sum[WIDTH-1:0];
                end
              end else begin
                if (w_dn_hit) begin
                  r_value <= r_target;
                  r_state <= S_IDLE;
                  r_done  <= 1'b1;
                end else begin
                  r_value <= w_diff[WIDTH-1:0];
                end
              end
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_fader.sv
// tb/tb_pwm_fader.sv - Directed bench for pwm_fader with hand-computed duty sequences.
module tb_pwm_fader;

  logic       clk;
  logic       rst;
  logic       sync;
  logic [7:0] target;
  logic [7:0] step;
  logic [7:0] interval;
  logic       target_valid;
  logic       target_ready;
  logic       abort;
  logic [7:0] value_out;
  logic       busy;
  logic       done;

  int n_checks;
  int n_pass;

  logic [7:0] s_val;
  logic       s_done;
  logic       s_busy;

  pwm_fader #(.WIDTH(8), .INIT(0)) dut (
    .clk          (clk),
    .rst          (rst),
    .sync         (sync),
    .target       (target),
    .step         (step),
    .interval     (interval),
    .target_valid (target_valid),
    .target_ready (target_ready),
    .abort        (abort),
    .value_out    (value_out),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic tick_clk(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic req(input logic [7:0] t, input logic [7:0] s, input logic [7:0] iv);
    target = t; step = s; interval = iv; target_valid = 1'b1;
    tick_clk(1);
    target_valid = 1'b0;
    target = 8'hAA; step = 8'h55; interval = 8'd7;
  endtask

  // Sync held high two clocks so a multi-clock marker must still yield a single step.
  task automatic sync_rise();
    sync = 1'b1;
    tick_clk(1);
    s_val = value_out; s_done = done; s_busy = busy;
    tick_clk(1);
    sync = 1'b0;
    tick_clk(1);
  endtask

  initial begin
    n_checks = 0; n_pass = 0;
    rst = 1'b1; sync = 1'b0; target = '0; step = '0; interval = '0;
    target_valid = 1'b0; abort = 1'b0;
    tick_clk(2);
    check("rst_value", value_out, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", target_ready, 1);
    check("rst_done", done, 0);
    rst = 1'b0;
    tick_clk(2);

    // Ramp up 0 -> 200 in steps of 50
    req(8'd200, 8'd50, 8'd1);
    check("up_busy", busy, 1);
    check("up_ready", target_ready, 0);
    for (int k = 1; k <= 4; k++) begin
      sync_rise();
      check($sformatf("up_val%0d", k), s_val, 50 * k);
      check($sformatf("up_done%0d", k), s_done, (k == 4) ? 1 : 0);
    end
    check("up_done_width", done, 0);
    check("up_ready_end", target_ready, 1);
    check("up_hold", value_out, 200);

    // Ramp down 200 -> 10, step 64, every 2nd sync rise
    req(8'd10, 8'd64, 8'd2);
    begin
      logic [7:0] exp_dn [6];
      exp_dn = '{8'd200, 8'd136, 8'd136, 8'd72, 8'd72, 8'd10};
      for (int k = 0; k < 6; k++) begin
        sync_rise();
        check($sformatf("dn_val%0d", k), s_val, exp_dn[k]);
        check($sformatf("dn_done%0d", k), s_done, (k == 5) ? 1 : 0);
      end
    end
    check("dn_busy_end", busy, 0);

    // Saturation at the top: 10 -> 250, then 250 -> 255 with step 20
    req(8'd250, 8'd240, 8'd1);
    sync_rise();
    check("sat_pre", s_val, 250);
    req(8'd255, 8'd20, 8'd0);
    sync_rise();
    check("sat_val", s_val, 255);
    check("sat_done", s_done, 1);
    check("sat_busy", s_busy, 0);

    // Request equal to current value
    req(8'd255, 8'd3, 8'd1);
    check("eq_done", done, 1);
    check("eq_ready", target_ready, 1);
    check("eq_val", value_out, 255);
    tick_clk(1);
    check("eq_done_width", done, 0);

    // Abort coinciding with a step; a request during the ramp must be dropped
    req(8'd0, 8'd100, 8'd1);
    sync_rise();
    check("ab_first", s_val, 155);
    target = 8'd5; step = 8'd1; interval = 8'd1; target_valid = 1'b1;
    tick_clk(1);
    target_valid = 1'b0;
    check("ab_ignored_busy", busy, 1);
    sync = 1'b1; abort = 1'b1;
    tick_clk(1);
    abort = 1'b0;
    check("ab_val", value_out, 155);
    check("ab_busy", busy, 0);
    check("ab_done", done, 0);
    check("ab_ready", target_ready, 1);
    sync = 1'b0;
    tick_clk(1);
    check("ab_done_late", done, 0);
    sync_rise();
    check("ab_no_queue", s_val, 155);
    check("ab_no_queue_busy", s_busy, 0);

    // Abort in IDLE is ignored: request still accepted
    abort = 1'b1;
    req(8'd200, 8'd10, 8'd1);
    abort = 1'b0;
    check("idle_abort_busy", busy, 1);
    sync_rise();
    check("rr_step", s_val, 165);

    // Asynchronous reset mid-ramp, released with sync high
    sync = 1'b1;
    #3 rst = 1'b1;
    #1;
    check("ar_val", value_out, 0);
    check("ar_busy", busy, 0);
    check("ar_ready", target_ready, 1);
    tick_clk(1);
    rst = 1'b0;
    req(8'd100, 8'd10, 8'd1);
    tick_clk(2);
    check("ar_no_tick", value_out, 0);
    check("ar_busy2", busy, 1);
    sync = 1'b0;
    tick_clk(1);
    sync_rise();
    check("ar_first_step", s_val, 10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
